// File: rtl/i2c_slave_regfile_if.sv
// Pin and register-port bundle for i2c_slave_regfile.
interface i2c_slave_regfile_if #(
  parameter int PTR_W = 8
);
  logic             in_scl;
  logic             in_sda;
  logic             out_sda_oe;
  logic             out_scl_oe;
  logic             out_wr_en;
  logic [PTR_W-1:0] out_wr_addr;
  logic [7:0]       out_wr_data;
  logic             out_rd_en;
  logic [PTR_W-1:0] out_rd_addr;
  logic [7:0]       in_rd_data;
  logic             in_busy;
  logic             out_active;

  modport slave (
    input  in_scl, in_sda, in_rd_data, in_busy,
    output out_sda_oe, out_scl_oe, out_wr_en, out_wr_addr, out_wr_data,
           out_rd_en, out_rd_addr, out_active
  );

  modport master (
    output in_scl, in_sda, in_rd_data, in_busy,
    input  out_sda_oe, out_scl_oe, out_wr_en, out_wr_addr, out_wr_data,
           out_rd_en, out_rd_addr, out_active
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C slave with pointer-based byte register access.
// Optional clock stretching on ACK bits: define I2C_CLK_STRETCH_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADDR    = 7'h50,
  parameter int         PTR_W       = 8,
  parameter int         NUM_REGS    = 256,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  i2c_slave_regfile_if.slave bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  // Sync chains reset high so an idle bus produces no edges out of reset.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.in_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.in_sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = ~sda_s & sda_d & scl_s;
  assign stop_det  = sda_s & ~sda_d & scl_s;

  logic [2:0]       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       sr;
  logic             rw, ack_ph, first, rd_q;
  logic [PTR_W-1:0] ptr;
  logic             sda_oe, scl_oe, wr_en, rd_en, active;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  logic [7:0]       wr_data;
  logic [7:0]       rx_byte;

  assign rx_byte = {sr[6:0], sda_s};

  function automatic logic [PTR_W-1:0] ptr_load(input logic [7:0] b);
    logic [31:0] v;
    v = {24'd0, b} & ((32'd1 << PTR_W) - 32'd1);
    return PTR_W'(v % NUM_REGS);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      rw      <= 1'b0;
      ack_ph  <= 1'b0;
      first   <= 1'b0;
      rd_q    <= 1'b0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      active  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      // Host returns data the cycle after rd_en; capture it one cycle later still.
      rd_q  <= rd_en;
      if (rd_q) sr <= bus.in_rd_data;

      if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        active <= 1'b0;
      end else if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        active  <= 1'b0;
      end else begin
        case (state)
          S_ADDR:
            if (scl_rise) begin
              sr      <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (sr[6:0] == I2C_ADDR) begin
                  state  <= S_ADDR_ACK;
                  rw     <= sda_s;
                  ack_ph <= 1'b0;
                  first  <= 1'b1;
                  active <= 1'b1;
                  if (sda_s) begin
                    rd_en   <= 1'b1;
                    rd_addr <= ptr;
                  end
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          S_ADDR_ACK, S_WR_ACK:
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                ack_ph  <= 1'b0;
                bit_cnt <= '0;
                if (state == S_ADDR_ACK && rw) begin
                  state  <= S_RD_BYTE;
                  sda_oe <= ~sr[7];
                end else begin
                  state  <= S_WR_BYTE;
                  sda_oe <= 1'b0;
                end
              end
            end
          S_WR_BYTE:
            if (scl_rise) begin
              sr      <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state  <= S_WR_ACK;
                ack_ph <= 1'b0;
                if (first) begin
                  first <= 1'b0;
                  ptr   <= ptr_load(rx_byte);
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= rx_byte;
                  ptr     <= ptr_inc(ptr);
                end
              end
            end
          S_RD_BYTE:
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= S_RD_ACK;
                sda_oe <= 1'b0;
                ack_ph <= 1'b0;
                ptr    <= ptr_inc(ptr);
              end else begin
                sda_oe <= ~sr[6];
                sr     <= {sr[6:0], 1'b0};
              end
            end
          S_RD_ACK:
            if (scl_rise) begin
              if (!sda_s) begin
                ack_ph  <= 1'b1;
                rd_en   <= 1'b1;
                rd_addr <= ptr;
              end else begin
                state  <= S_IDLE;
                active <= 1'b0;
              end
            end else if (scl_fall && ack_ph) begin
              state   <= S_RD_BYTE;
              sda_oe  <= ~sr[7];
              bit_cnt <= '0;
              ack_ph  <= 1'b0;
            end
          default: state <= S_IDLE;
        endcase
      end
    end

`ifdef I2C_CLK_STRETCH_EN
  // ack_ph is only set on the second half of an ACK bit (or a master ACK).
  logic ack_end;
  assign ack_end = scl_fall & ~start_det & ~stop_det & ack_ph &
                   ((state == S_ADDR_ACK) | (state == S_WR_ACK) | (state == S_RD_ACK));
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n)
      scl_oe <= 1'b0;
    else if (scl_oe) begin
      if (!bus.in_busy) scl_oe <= 1'b0;
    end else if (ack_end && bus.in_busy)
      scl_oe <= 1'b1;
`else
  logic unused_busy;
  assign unused_busy = bus.in_busy;
  assign scl_oe      = 1'b0;
`endif

  assign bus.out_sda_oe  = sda_oe;
  assign bus.out_scl_oe  = scl_oe;
  assign bus.out_wr_en   = wr_en;
  assign bus.out_wr_addr = wr_addr;
  assign bus.out_wr_data = wr_data;
  assign bus.out_rd_en   = rd_en;
  assign bus.out_rd_addr = rd_addr;
  assign bus.out_active  = active;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: two slaves (0x50/256 regs, 0x51/16 regs) on one bus.
module tb_i2c_slave_regfile;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  i2c_slave_regfile_if #(.PTR_W(8)) bus ();
  i2c_slave_regfile_if #(.PTR_W(8)) bus16 ();

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire scl_line = scl_m & ~bus.out_scl_oe & ~bus16.out_scl_oe;
  wire sda_line = sda_m & ~bus.out_sda_oe & ~bus16.out_sda_oe;

  assign bus.in_scl     = scl_line;
  assign bus.in_sda     = sda_line;
  assign bus16.in_scl   = scl_line;
  assign bus16.in_sda   = sda_line;
  assign bus16.in_busy  = 1'b0;
  assign bus16.in_rd_data = 8'h00;

  i2c_slave_regfile #(.I2C_ADDR(7'h50), .PTR_W(8), .NUM_REGS(256), .SYNC_STAGES(2)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .bus(bus));
  i2c_slave_regfile #(.I2C_ADDR(7'h51), .PTR_W(8), .NUM_REGS(16), .SYNC_STAGES(3)) dut16 (
    .in_clk(clk), .in_rst_n(rst_n), .bus(bus16));

  // Host model and strobe logs.
  logic [15:0] wr_q[$];
  logic [15:0] wr16_q[$];
  logic [7:0]  rd_q[$];
  int rd16_cnt = 0;
  int scl_oe_hi = 0;
  always @(negedge clk) begin
    if (!rst_n) bus.in_rd_data = 8'h00;
    if (bus.out_wr_en) wr_q.push_back({bus.out_wr_addr, bus.out_wr_data});
    if (bus16.out_wr_en) wr16_q.push_back({bus16.out_wr_addr, bus16.out_wr_data});
    if (bus.out_rd_en) begin
      rd_q.push_back(bus.out_rd_addr);
      bus.in_rd_data = bus.out_rd_addr + 8'h40;
    end
    if (bus16.out_rd_en) rd16_cnt++;
    if (bus.out_scl_oe | bus16.out_scl_oe) scl_oe_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    scl_m = 1'b1;
    for (int i = 0; i < 2000 && !scl_line; i++) @(negedge clk);
    total++;
    if (scl_line !== 1'b1) begin
      bad++;
      $display("FAIL scl_release: scl=%b expected 1", scl_line);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; wt(H/2);
    scl_high(); wt(H/2);
    s = sda_line; wt(H/2);
    scl_m = 1'b0; wt(H/2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wt(H/2);
    scl_high(); wt(H/2);
    sda_m = 1'b0; wt(H/2);
    scl_m = 1'b0; wt(H/2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt(H/2);
    scl_high(); wt(H/2);
    sda_m = 1'b1; wt(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wt(4);
    total++;
    if ({bus.out_sda_oe, bus.out_scl_oe, bus.out_wr_en, bus.out_rd_en, bus.out_active} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.out_sda_oe, bus.out_scl_oe, bus.out_wr_en, bus.out_rd_en, bus.out_active});
    end
    total++;
    if ({bus.out_wr_addr, bus.out_wr_data, bus.out_rd_addr} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %h expected 000000",
               {bus.out_wr_addr, bus.out_wr_data, bus.out_rd_addr});
    end
    rst_n = 1'b1;
    wt(4);
  endtask

  task automatic test_write_burst();
    logic [7:0] tx[5];
    logic       ack;
    int         n0;
    tx = '{8'hA0, 8'h10, 8'h11, 8'h22, 8'h33};
    n0 = wr_q.size();
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(tx[i], ack);
      total++;
      if (ack !== 1'b1) begin
        bad++;
        $display("FAIL wr_ack[%0d]: ack=%b expected 1", i, ack);
      end
    end
    total++;
    if (bus.out_active !== 1'b1) begin
      bad++;
      $display("FAIL wr_active: got %b expected 1", bus.out_active);
    end
    i2c_stop();
    total++;
    if (bus.out_active !== 1'b0) begin
      bad++;
      $display("FAIL wr_active_stop: got %b expected 0", bus.out_active);
    end
    total++;
    if (wr_q.size() - n0 != 3) begin
      bad++;
      $display("FAIL wr_count: got %0d expected 3", wr_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_q[n0+i] !== {8'(8'h10 + i), tx[2+i]}) begin
          bad++;
          $display("FAIL wr_strobe[%0d]: got %h expected %h", i, wr_q[n0+i], {8'(8'h10 + i), tx[2+i]});
        end
      end
    end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_b[3];
    logic [7:0] b;
    logic       ack;
    int         r0;
    exp_b = '{8'h45, 8'h46, 8'h47};
    r0 = rd_q.size();
    i2c_start();
    write_byte(8'hA0, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_w_ack: ack=%b expected 1", ack); end
    write_byte(8'h05, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL rd_ptr_ack: ack=%b expected 1", ack); end
    i2c_start();
    write_byte(8'hA1, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_r_ack: ack=%b expected 1", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte(i < 2, b);
      total++;
      if (b !== exp_b[i]) begin
        bad++;
        $display("FAIL rd_byte[%0d]: got %h expected %h", i, b, exp_b[i]);
      end
    end
    wt(H/2);
    total++;
    if ({bus.out_sda_oe, bus.out_active} !== 2'b00) begin
      bad++;
      $display("FAIL rd_nack_release: oe,active=%b expected 00", {bus.out_sda_oe, bus.out_active});
    end
    i2c_stop();
    total++;
    if (rd_q.size() - r0 != 3) begin
      bad++;
      $display("FAIL rd_count: got %0d expected 3", rd_q.size() - r0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rd_q[r0+i] !== 8'(5 + i)) begin
          bad++;
          $display("FAIL rd_addr[%0d]: got %h expected %h", i, rd_q[r0+i], 8'(5 + i));
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    logic ack;
    int   w0, w1, r0, r1;
    w0 = wr_q.size(); w1 = wr16_q.size(); r0 = rd_q.size(); r1 = rd16_cnt;
    i2c_start();
    write_byte(8'hA4, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL bad_addr_ack: ack=%b expected 0", ack); end
    total++;
    if (bus.out_active !== 1'b0) begin
      bad++;
      $display("FAIL bad_addr_active: got %b expected 0", bus.out_active);
    end
    write_byte(8'h00, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL bad_addr_idle: ack=%b expected 0", ack); end
    i2c_stop();
    total++;
    if (wr_q.size() != w0 || wr16_q.size() != w1 || rd_q.size() != r0 || rd16_cnt != r1) begin
      bad++;
      $display("FAIL bad_addr_strobes: got %0d new strobes expected 0",
               wr_q.size() - w0 + wr16_q.size() - w1 + rd_q.size() - r0 + rd16_cnt - r1);
    end
  endtask

  task automatic test_wrap16();
    logic [7:0]  tx[7];
    logic [15:0] exp_w[3];
    logic        ack;
    int          n0, m0;
    tx    = '{8'hA2, 8'h0F, 8'hAB, 8'hCD, 8'hA2, 8'h13, 8'h77};
    exp_w = '{16'h0FAB, 16'h00CD, 16'h0377};
    n0 = wr16_q.size(); m0 = wr_q.size();
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || i == 4) i2c_start();
      write_byte(tx[i], ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("FAIL wrap_ack[%0d]: ack=%b expected 1", i, ack); end
      if (i == 3 || i == 6) i2c_stop();
    end
    total++;
    if (wr16_q.size() - n0 != 3 || wr_q.size() != m0) begin
      bad++;
      $display("FAIL wrap_count: got %0d/%0d expected 3/0", wr16_q.size() - n0, wr_q.size() - m0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr16_q[n0+i] !== exp_w[i]) begin
          bad++;
          $display("FAIL wrap_strobe[%0d]: got %h expected %h", i, wr16_q[n0+i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] bits;
    logic [7:0] b;
    logic       ack, s;
    int         n0;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 2; i >= 0; i--) begin
      clk_bit(1'b1, s);
      bits[i] = s;
    end
    total++;
    if (bits !== 3'b010) begin bad++; $display("FAIL rst_bits: got %b expected 010", bits); end
    sda_m = 1'b1; wt(H/2);
    total++;
    if (bus.out_sda_oe !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_drive: oe=%b expected 1", bus.out_sda_oe);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_sda_oe, bus.out_active} !== 2'b00) begin
      bad++;
      $display("FAIL rst_release: oe,active=%b expected 00", {bus.out_sda_oe, bus.out_active});
    end
    wt(3);
    rst_n = 1'b1;
    wt(H);
    // Pointer restarts at 0 after reset.
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(1'b0, b);
    i2c_stop();
    total++;
    if (ack !== 1'b1 || b !== 8'h40) begin
      bad++;
      $display("FAIL rst_post_read: ack=%b byte=%h expected 1 40", ack, b);
    end
    n0 = wr_q.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    write_byte(8'h99, ack);
    i2c_stop();
    total++;
    if (wr_q.size() - n0 != 1 || wr_q[wr_q.size()-1] !== 16'h2099 || ack !== 1'b1) begin
      bad++;
      $display("FAIL rst_post_write: count=%0d last=%h expected 1 2099", wr_q.size() - n0,
               wr_q[wr_q.size()-1]);
    end
  endtask

  task automatic test_stretch();
`ifdef I2C_CLK_STRETCH_EN
    logic [7:0] d;
    logic       ack, s;
    int         cnt, n0;
    n0 = wr_q.size();
    d = 8'h5A;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    bus.in_busy = 1'b1;
    sda_m = 1'b1; wt(H/2);
    scl_high(); wt(H/2);
    s = sda_line; wt(H/2);
    scl_m = 1'b0;
    for (int i = 0; i < 20 && !bus.out_scl_oe; i++) @(negedge clk);
    total++;
    if (bus.out_scl_oe !== 1'b1) begin
      bad++;
      $display("FAIL stretch_start: scl_oe=%b expected 1", bus.out_scl_oe);
    end
    cnt = 1;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_scl_oe) cnt++;
    end
    bus.in_busy = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_scl_oe !== 1'b0) begin
      bad++;
      $display("FAIL stretch_end: scl_oe=%b expected 0", bus.out_scl_oe);
    end
    total++;
    if (cnt != 51) begin bad++; $display("FAIL stretch_len: got %0d expected 51", cnt); end
    write_byte(8'h66, ack);
    i2c_stop();
    total++;
    if (s !== 1'b0 || wr_q.size() - n0 != 2) begin
      bad++;
      $display("FAIL stretch_writes: ack_sda=%b count=%0d expected 0 2", s, wr_q.size() - n0);
    end else begin
      total++;
      if (wr_q[n0] !== 16'h305A || wr_q[n0+1] !== 16'h3166) begin
        bad++;
        $display("FAIL stretch_data: got %h %h expected 305a 3166", wr_q[n0], wr_q[n0+1]);
      end
    end
`else
    total++;
    if (scl_oe_hi != 0) begin
      bad++;
      $display("FAIL no_stretch: scl_oe high %0d cycles expected 0", scl_oe_hi);
    end
`endif
  endtask

  initial begin
    bus.in_busy = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_bad_addr();
    test_wrap16();
    test_reset_mid_read();
    test_stretch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
